// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that feeds N one-entry result slots onto a registered CDB. Results reach the bus 2 cycles after the handshake.
// A slot accepts a new result when it is empty or is being granted. Results with an INVALID tag are counted as drops and never broadcast.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  input  logic [N_REQ*DATA_W-1:0]    req_val,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_val,
  output logic [$clog2(N_REQ)-1:0]   cdb_src,
  output logic [7:0]                 drop_cnt
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam logic [TAG_W-1:0] TAG_INV = '1;
  localparam logic [SRC_W:0]   N_EXT   = (SRC_W+1)'(N_REQ);
  localparam logic [SRC_W-1:0] LAST    = SRC_W'(N_REQ-1);

  logic [N_REQ-1:0]  slot_v;
  logic [TAG_W-1:0]  slot_tag [N_REQ];
  logic [DATA_W-1:0] slot_val [N_REQ];
  logic [SRC_W-1:0]  ptr;

  logic [N_REQ-1:0]  grant;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_any;
  logic [SRC_W:0]    idx;
  logic [N_REQ-1:0]  xfer;
  logic [N_REQ-1:0]  tag_inv;
  logic [N_REQ-1:0]  load;
  logic [3:0]        drop_add;
  logic [8:0]        drop_sum;

  // Walk the slots starting at ptr, wrapping explicitly so non-power-of-two N_REQ never indexes past the end.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = {1'b0, ptr} + (SRC_W+1)'(off);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!grant_any && slot_v[idx[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
    grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  end

  assign req_ready = {N_REQ{~flush}} & (~slot_v | grant);
  assign xfer      = req_valid & req_ready;
  assign load      = xfer & ~tag_inv;
  assign drop_sum  = {1'b0, drop_cnt} + 9'(drop_add);

  always_comb begin
    tag_inv  = '0;
    drop_add = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tag_inv[i] = (req_tag[i*TAG_W +: TAG_W] == TAG_INV);
      drop_add   = drop_add + 4'(xfer[i] & tag_inv[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_v    <= '0;
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= TAG_INV;
      cdb_val   <= '0;
      cdb_src   <= '0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (flush) begin
        slot_v    <= '0;
        ptr       <= '0;
        cdb_valid <= 1'b0;
        cdb_tag   <= TAG_INV;
        cdb_val   <= '0;
      end else begin
        if (grant_any) begin
          cdb_valid <= 1'b1;
          cdb_tag   <= slot_tag[grant_idx];
          cdb_val   <= slot_val[grant_idx];
          cdb_src   <= grant_idx;
          ptr       <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end else begin
          cdb_valid <= 1'b0;
          cdb_tag   <= TAG_INV;
          cdb_val   <= '0;
        end
        // A granted slot that is refilled in the same cycle stays occupied.
        slot_v <= (slot_v & ~grant) | load;
      end
    end
  end

  // Slot payload needs no reset; it is only meaningful while slot_v is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (load[i]) begin
        slot_tag[i] <= req_tag[i*TAG_W +: TAG_W];
        slot_val[i] <= req_val[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N functional-unit result ports in the out-of-order core.
- Each requester hands over one completed {tag, value} result through a valid/ready handshake into a private one-entry holding slot.
- A round-robin arbiter picks one occupied slot per cycle and drives the registered CDB broadcast, which the map table, reservation stations and register file consume.
- Also provides flush support and a saturating drop counter for results carrying an invalid tag.

Parameters:
N_REQ, 4, number of requesting result ports (2..8)
TAG_W, 4, reservation-station tag width; the all-ones tag is INVALID
DATA_W, 32, result value width

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
flush  in  1  pipeline flush: discard all held results
req_valid  in  N_REQ  per-requester result valid
req_tag  in  N_REQ*TAG_W  per-requester RS tag, requester i in bits [i*TAG_W +: TAG_W]
req_val  in  N_REQ*DATA_W  per-requester result value, requester i in bits [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  per-requester ready (combinational)
cdb_valid  out  1  broadcast valid (registered)
cdb_tag  out  TAG_W  broadcast tag (registered)
cdb_val  out  DATA_W  broadcast value (registered)
cdb_src  out  $clog2(N_REQ)  index of requester whose result is on the bus (registered)
drop_cnt  out  8  saturating count of results discarded for INVALID tag

Behaviour:
- Reset (RST=1 at an edge): all slots empty; round-robin pointer ptr=0; cdb_valid=0; cdb_tag=all-ones; cdb_val=0; cdb_src=0; drop_cnt=0. Reset overrides flush and all handshakes.
- Slot state per requester i: slot_v[i], slot_tag[i], slot_val[i].
- req_ready[i] = !flush & (!slot_v[i] | grant[i]). A slot can therefore be refilled in the same cycle it is granted, sustaining one result per cycle per port.
- Handshake: transfer occurs when req_valid[i] & req_ready[i] at the edge. Values must stay stable while req_valid=1 and ready=0.
- INVALID-tag transfer (req_tag == all-ones):
  - Handshake completes; slot is not loaded.
  - drop_cnt increments, saturating at 255.
  - Multiple simultaneous drops in one cycle add their count, still saturating.
- Arbitration is combinational over slot_v only, so a result is never eligible in its own transfer cycle. Search order is ptr, ptr+1, ... wrapping modulo N_REQ; the first occupied slot k gets grant[k]=1. At most one grant per cycle.
- On a grant at the edge:
  - cdb_valid<=1, cdb_tag<=slot_tag[k], cdb_val<=slot_val[k], cdb_src<=k.
  - slot_v[k] is cleared unless it is refilled the same cycle.
  - ptr<=(k+1) mod N_REQ (wrap from N_REQ-1 to 0).
- No occupied slot: cdb_valid<=0, cdb_tag<=all-ones, cdb_val<=0, cdb_src holds; ptr unchanged.
- Latency: handshake at edge t -> earliest cdb_valid=1 in the cycle after edge t+1 (2 cycles). The broadcast lasts exactly one cycle per result.
- Fairness: with all N_REQ slots continuously occupied, each requester is granted exactly once every N_REQ cycles.
- Flush (flush=1 at an edge, RST=0):
  - All slot_v cleared; no grant issued; cdb_valid<=0, cdb_tag<=all-ones, cdb_val<=0; ptr<=0.
  - req_ready is 0 during the flush cycle, so no transfers occur.
  - A broadcast already registered before the flush edge is still visible for its one cycle.
  - drop_cnt is not affected by flush.
- Reset mid-operation: held results are lost and no partial broadcast occurs; the cycle after reset shows cdb_valid=0.
- N_REQ not a power of two: ptr wraps explicitly at N_REQ-1; index values >= N_REQ never occur.

Test Plan:
- Single request: after reset, req0 sends tag 3, val 0xDEADBEEF for one cycle -> req_ready[0]=1; two cycles later cdb_valid=1, tag 3, val 0xDEADBEEF, cdb_src=0 for exactly one cycle, then cdb_valid=0, tag 0xF.
- Simultaneous: all 4 requesters present tags 1,2,4,5 in the same cycle with ptr=0 -> broadcasts in order src 0,1,2,3 on 4 consecutive cycles; ptr ends at 0.
- Round-robin wrap: keep all 4 slots refilled every grant for 12 cycles -> cdb_src sequence 0,1,2,3 repeated 3 times; req_ready[i]=1 only in the cycle requester i is granted.
- Back-pressure: req1 holds slot and presents a second result while req0 is granted first -> req_ready[1]=0 that cycle; second value accepted the cycle slot 1 is granted; no value lost or duplicated.
- Invalid tag: req2 sends tag 0xF 300 times -> no CDB broadcast; drop_cnt reads 255 (saturated).
- Flush/reset mid-flight: slots 0 and 3 occupied, assert flush one cycle -> req_ready all 0 that cycle, no further broadcasts, ptr=0; repeat with RST instead -> all outputs at reset values the next cycle.
